// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and repeat issuer feeding the 4-bit accumulator ALU
// Idle and stalled cycles present OR/0 so the accumulator holds its value.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [3:0]    in_operand,
  input  logic [1:0]    in_rpt,
  input  logic          stall,
  input  logic          flush,
  output logic [1:0]    alu_op,
  output logic [3:0]    alu_operand,
  output logic          alu_issue,
  output logic [CW-1:0] fifo_count,
  output logic          busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] OP_NOP = 2'b10;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t        state, state_next;
  logic [1:0]    op_mem      [DEPTH];
  logic [3:0]    operand_mem [DEPTH];
  logic [1:0]    rpt_mem     [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [1:0]    rcnt, rcnt_next;
  logic [1:0]    op_next;
  logic [3:0]    operand_next;
  logic          push, pop;

  assign in_ready  = (fifo_count < CW'(DEPTH)) && !flush;
  assign push      = in_valid && in_ready;
  assign busy      = (fifo_count != '0);
  assign alu_issue = (state == S_ISSUE);

  // Next issue decision; flush wins over everything by leaving the NOP defaults.
  always_comb begin
    state_next   = S_IDLE;
    op_next      = OP_NOP;
    operand_next = 4'b0000;
    rcnt_next    = rcnt;
    pop          = 1'b0;
    if (flush) begin
      rcnt_next = 2'b00;
    end else if (busy && !stall) begin
      state_next   = S_ISSUE;
      op_next      = op_mem[rptr];
      operand_next = operand_mem[rptr];
      if (rcnt == rpt_mem[rptr]) begin
        pop       = 1'b1;
        rcnt_next = 2'b00;
      end else begin
        rcnt_next = rcnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      alu_op      <= OP_NOP;
      alu_operand <= 4'b0000;
      rcnt        <= 2'b00;
      wptr        <= '0;
      rptr        <= '0;
      fifo_count  <= '0;
    end else begin
      state       <= state_next;
      alu_op      <= op_next;
      alu_operand <= operand_next;
      rcnt        <= rcnt_next;
      if (flush) begin
        wptr       <= '0;
        rptr       <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wptr]      <= in_op;
      operand_mem[wptr] <= in_operand;
      rpt_mem[wptr]     <= in_rpt;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, stall, flush, alu_issue, busy;
  logic [1:0]    in_op, in_rpt, alu_op;
  logic [3:0]    in_operand, alu_operand;
  logic [CW-1:0] fifo_count;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_operand(in_operand), .in_rpt(in_rpt),
    .stall(stall), .flush(flush), .alu_op(alu_op), .alu_operand(alu_operand),
    .alu_issue(alu_issue), .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [3:0] opd;
    logic [1:0] rpt;
  } cmd_t;

  cmd_t       q[$];
  int         rep;
  logic [1:0] e_op;
  logic [3:0] e_opd;
  logic       e_iss, e_ready, obs_ready;
  logic [3:0] acc;
  int         errors = 0;
  int         checks = 0;

  // One clock: drive inputs, note in_ready before the edge, advance the queue model.
  task automatic tick(input logic v, input logic [1:0] op, input logic [3:0] opd,
                      input logic [1:0] rpt, input logic st, input logic fl, input logic rs);
    cmd_t c;
    logic room;
    reset = rs; in_valid = v; in_op = op; in_operand = opd; in_rpt = rpt;
    stall = st; flush = fl;
    #1;
    obs_ready = in_ready;
    e_ready   = (q.size() < DEPTH) && !fl;
    @(posedge clk);
    e_op = 2'b10; e_opd = 4'h0; e_iss = 1'b0;
    if (rs || fl) begin
      q.delete();
      rep = 0;
    end else begin
      room = (q.size() < DEPTH);
      if (q.size() > 0 && !st) begin
        e_op = q[0].op; e_opd = q[0].opd; e_iss = 1'b1;
        rep++;
        if (rep > int'(q[0].rpt)) begin
          void'(q.pop_front());
          rep = 0;
        end
      end
      if (v && room) begin
        c.op = op; c.opd = opd; c.rpt = rpt;
        q.push_back(c);
      end
    end
    #1;
    if (rs) acc = 4'h0;
    else case (alu_op)
      2'b00: acc = acc + alu_operand;
      2'b01: acc = acc - alu_operand;
      2'b10: acc = acc | alu_operand;
      default: acc = acc ^ alu_operand;
    endcase
  endtask

  task automatic idle(input logic st);
    tick(1'b0, 2'b00, 4'h0, 2'b00, st, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    tick(1'b0, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      checks++;
      if ({alu_op, alu_operand, alu_issue, in_ready, fifo_count, busy} !== {2'b10, 4'h0, 1'b0, 1'b1, 3'd0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: op=%b opd=%h iss=%b rdy=%b cnt=%0d busy=%b, need op=10 opd=0 iss=0 rdy=1 cnt=0 busy=0",
                 i, alu_op, alu_operand, alu_issue, in_ready, fifo_count, busy);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [6:0] exp [5];
    exp[0] = 7'b10_0000_0; exp[1] = 7'b00_0011_1; exp[2] = 7'b01_0001_1;
    exp[3] = 7'b11_1111_1; exp[4] = 7'b10_0000_0;
    tick(1'b0, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: tick(1'b1, 2'b00, 4'h3, 2'b00, 1'b0, 1'b0, 1'b0);
        1: tick(1'b1, 2'b01, 4'h1, 2'b00, 1'b0, 1'b0, 1'b0);
        2: tick(1'b1, 2'b11, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0);
        default: idle(1'b0);
      endcase
      checks++;
      if ({alu_op, alu_operand, alu_issue} !== exp[i]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b need %b", i, {alu_op, alu_operand, alu_issue}, exp[i]);
      end
    end
    checks++;
    if (acc !== 4'hD) begin
      errors++;
      $display("FAIL back_to_back_acc: got %h need d", acc);
    end
  endtask

  task automatic test_repeat;
    int exp_cnt [5];
    exp_cnt[0] = 1; exp_cnt[1] = 1; exp_cnt[2] = 1; exp_cnt[3] = 1; exp_cnt[4] = 0;
    tick(1'b0, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 4'h2, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (int'(fifo_count) != exp_cnt[i]) begin
        errors++;
        $display("FAIL repeat_count step %0d: got %0d need %0d", i, fifo_count, exp_cnt[i]);
      end
      idle(1'b0);
      checks++;
      if ({alu_op, alu_operand, alu_issue} !== ((i < 4) ? 7'b00_0010_1 : 7'b10_0000_0)) begin
        errors++;
        $display("FAIL repeat_issue step %0d: got %b", i, {alu_op, alu_operand, alu_issue});
      end
    end
    checks++;
    if (acc !== 4'h8) begin
      errors++;
      $display("FAIL repeat_acc: got %h need 8", acc);
    end
  endtask

  task automatic test_fill_stall;
    int issues = 0;
    tick(1'b0, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) tick(1'b1, 2'(k), 4'(k + 5), 2'b11, 1'b1, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: rdy=%b cnt=%0d, need rdy=0 cnt=4", in_ready, fifo_count);
    end
    tick(1'b1, 2'b11, 4'h9, 2'b00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_ready !== 1'b0 || fifo_count !== 3'd4 || alu_issue !== 1'b0) begin
      errors++;
      $display("FAIL fill_fifth: rdy=%b cnt=%0d iss=%b, need 0/4/0", obs_ready, fifo_count, alu_issue);
    end
    for (int j = 0; j < 17; j++) begin
      idle(1'b0);
      if (alu_issue) issues++;
      if (j < 16) begin
        checks++;
        if (alu_op !== 2'(j / 4) || alu_operand !== 4'(j / 4 + 5) || alu_issue !== 1'b1) begin
          errors++;
          $display("FAIL fill_drain issue %0d: op=%b opd=%h iss=%b need op=%0d opd=%0d iss=1",
                   j, alu_op, alu_operand, alu_issue, j / 4, j / 4 + 5);
        end
      end
    end
    checks++;
    if (issues != 16 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_total: issues=%0d cnt=%0d busy=%b need 16/0/0", issues, fifo_count, busy);
    end
  endtask

  task automatic test_stall_mid;
    logic pat [8];
    pat[0] = 1; pat[1] = 1; pat[2] = 0; pat[3] = 0; pat[4] = 0; pat[5] = 1; pat[6] = 1; pat[7] = 0;
    tick(1'b0, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 2'b10, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      idle(i >= 2 && i <= 4);
      checks++;
      if (alu_issue !== pat[i] || (pat[i] && {alu_op, alu_operand} !== 6'b10_0100)) begin
        errors++;
        $display("FAIL stall_mid cycle %0d: iss=%b op=%b opd=%h need iss=%b", i, alu_issue, alu_op, alu_operand, pat[i]);
      end
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL stall_mid_count: got %0d need 0", fifo_count);
    end
  endtask

  task automatic test_flush_and_reset(input logic use_reset);
    tick(1'b0, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 2'b00, 4'h1, 2'b11, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 2'b01, 4'h2, 2'b01, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 2'b11, 4'h3, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fifo_count !== 3'd3 || alu_issue !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: cnt=%0d iss=%b need 3/1", fifo_count, alu_issue);
    end
    tick(1'b1, 2'b00, 4'h7, 2'b00, 1'b0, !use_reset, use_reset);
    checks++;
    if ({alu_op, alu_operand, alu_issue, fifo_count, busy} !== {2'b10, 4'h0, 1'b0, 3'd0, 1'b0}
        || (!use_reset && obs_ready !== 1'b0)) begin
      errors++;
      $display("FAIL clear_%0s: op=%b opd=%h iss=%b cnt=%0d busy=%b rdy=%b, need NOP empty",
               use_reset ? "reset" : "flush", alu_op, alu_operand, alu_issue, fifo_count, busy, obs_ready);
    end
    idle(1'b0);
    checks++;
    if (alu_issue !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL clear_after_%0s: iss=%b cnt=%0d need 0/0", use_reset ? "reset" : "flush", alu_issue, fifo_count);
    end
  endtask

  task automatic test_random;
    tick(1'b0, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(9, 0) < 7, 2'($urandom), 4'($urandom), 2'($urandom),
           $urandom_range(9, 0) < 2, $urandom_range(99, 0) < 3, $urandom_range(299, 0) == 0);
      checks++;
      if (obs_ready !== e_ready || alu_op !== e_op || alu_operand !== e_opd || alu_issue !== e_iss
          || int'(fifo_count) != q.size() || busy !== (q.size() != 0)) begin
        errors++;
        $display("FAIL random cycle %0d: rdy=%b op=%b opd=%h iss=%b cnt=%0d, need rdy=%b op=%b opd=%h iss=%b cnt=%0d",
                 i, obs_ready, alu_op, alu_operand, alu_issue, fifo_count, e_ready, e_op, e_opd, e_iss, q.size());
      end
    end
  endtask

  initial begin
    rep = 0; acc = 4'h0;
    reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_operand = 4'h0; in_rpt = 2'b00;
    stall = 1'b0; flush = 1'b0;
    test_reset;
    test_back_to_back;
    test_repeat;
    test_fill_stall;
    test_stall_mid;
    test_flush_and_reset(1'b0);
    test_flush_and_reset(1'b1);
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
